// File: rtl/tow_pkg.sv
// Shared types for the tug-of-war playfield.
// Round states and the encoding of the winner output.
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        L_WIN = 2'd1,
        R_WIN = 2'd2,
        OVER  = 2'd3
    } tow_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

endpackage

// File: rtl/tow_edge_detect.sv
// Rising-edge detector for a synchronised key level.
// Emits a single-cycle pulse on each 0->1 transition.
module tow_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: light bar, rounds, scores, hold and match-over.
// TOW_CPU_PLAYER_EN replaces the right key with an LFSR-driven CPU player.
module tug_of_war_field
    import tow_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int MAX_SCORE   = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  L,
    input  logic                  R,
`ifdef TOW_CPU_PLAYER_EN
    input  logic [9:0]            cpu_thresh,
`endif
    output logic [NUM_LIGHTS-1:0] leds,
    output logic [SCORE_W-1:0]    l_score,
    output logic [SCORE_W-1:0]    r_score,
    output logic [1:0]            winner,
    output logic                  match_over
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] CENTRE = PW'(NUM_LIGHTS / 2);
    localparam logic [PW-1:0] LEFT_END = PW'(NUM_LIGHTS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

    tow_state_e         state_q, state_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SCORE_W-1:0] l_score_q, l_score_d;
    logic [SCORE_W-1:0] r_score_q, r_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               lp, rp;

    tow_edge_detect u_edge_l (
        .clk     (clk),
        .rst_n   (reset),
        .level_i (L),
        .pulse_o (lp)
    );

`ifdef TOW_CPU_PLAYER_EN
    // Fibonacci LFSR, taps 10 and 7; the CPU presses whenever it falls below the threshold.
    logic [9:0] lfsr_q, lfsr_d;
    logic       unused_r;

    assign unused_r = R;
    assign lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign rp       = (lfsr_q < cpu_thresh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 10'h001;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    tow_edge_detect u_edge_r (
        .clk     (clk),
        .rst_n   (reset),
        .level_i (R),
        .pulse_o (rp)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= PLAY;
            pos_q     <= CENTRE;
            hold_q    <= '0;
            l_score_q <= '0;
            r_score_q <= '0;
            winner_q  <= WIN_NONE;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            hold_q    <= hold_d;
            l_score_q <= l_score_d;
            r_score_q <= r_score_d;
            winner_q  <= winner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        hold_d    = hold_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        winner_d  = winner_q;
        unique case (state_q)
            PLAY: begin
                if (lp && !rp) begin
                    if (pos_q == LEFT_END) begin
                        state_d   = L_WIN;
                        l_score_d = l_score_q + 1'b1;
                        winner_d  = WIN_L;
                        hold_d    = '0;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (rp && !lp) begin
                    if (pos_q == '0) begin
                        state_d   = R_WIN;
                        r_score_d = r_score_q + 1'b1;
                        winner_d  = WIN_R;
                        hold_d    = '0;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            L_WIN, R_WIN: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if ((state_q == L_WIN ? l_score_q : r_score_q) == SCORE_MAX) begin
                        state_d = OVER;
                    end else begin
                        state_d  = PLAY;
                        pos_d    = CENTRE;
                        winner_d = WIN_NONE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_comb begin
        leds = '0;
        if (state_q == PLAY) begin
            leds = NUM_LIGHTS'(1) << pos_q;
        end
    end

    assign l_score    = l_score_q;
    assign r_score    = r_score_q;
    assign winner     = winner_q;
    assign match_over = (state_q == OVER);

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed, table-driven bench for tug_of_war_field at default parameters.
module tb_tug_of_war_field;

    logic       clk;
    logic       reset;
    logic       L;
    logic       R;
    logic [8:0] leds;
    logic [2:0] l_score;
    logic [2:0] r_score;
    logic [1:0] winner;
    logic       match_over;
`ifdef TOW_CPU_PLAYER_EN
    logic [9:0] cpu_thresh;
`endif

    int checks = 0;
    int errors = 0;

    tug_of_war_field dut (
        .clk        (clk),
        .reset      (reset),
        .L          (L),
        .R          (R),
`ifdef TOW_CPU_PLAYER_EN
        .cpu_thresh (cpu_thresh),
`endif
        .leds       (leds),
        .l_score    (l_score),
        .r_score    (r_score),
        .winner     (winner),
        .match_over (match_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       l;
        logic       r;
        logic [8:0] leds;
        logic [2:0] ls;
        logic [2:0] rs;
        logic [1:0] win;
        logic       mo;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic l, logic r, logic [8:0] ld,
                                logic [2:0] ls, logic [2:0] rs,
                                logic [1:0] win, logic mo);
        vec_t v;
        v.l = l; v.r = r; v.leds = ld;
        v.ls = ls; v.rs = rs; v.win = win; v.mo = mo;
        vq.push_back(v);
    endfunction

    task automatic check(string name, logic [8:0] el, logic [2:0] els,
                         logic [2:0] ers, logic [1:0] ew, logic emo);
        checks++;
        if (leds !== el || l_score !== els || r_score !== ers ||
            winner !== ew || match_over !== emo) begin
            errors++;
            $display("FAIL %s: got leds=%b l=%0d r=%0d win=%b mo=%b, want leds=%b l=%0d r=%0d win=%b mo=%b",
                     name, leds, l_score, r_score, winner, match_over,
                     el, els, ers, ew, emo);
        end
    endtask

    task automatic do_reset();
        L = 1'b0;
        R = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic step(logic l, logic r);
        L = l;
        R = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef TOW_CPU_PLAYER_EN
        cpu_thresh = 10'h000;
`endif
        do_reset();
        check("reset", 9'h010, 3'd0, 3'd0, 2'b00, 1'b0);

`ifndef TOW_CPU_PLAYER_EN
        // Held L moves once; simultaneous presses cancel.
        add(1, 0, 9'h020, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 9'h020, 0, 0, 2'b00, 0);
        add(0, 0, 9'h020, 0, 0, 2'b00, 0);
        add(1, 1, 9'h020, 0, 0, 2'b00, 0);
        add(0, 0, 9'h020, 0, 0, 2'b00, 0);
        add(0, 1, 9'h010, 0, 0, 2'b00, 0);
        add(0, 0, 9'h010, 0, 0, 2'b00, 0);
        // Five L pulses from centre: left round win, R ignored in hold.
        add(1, 0, 9'h020, 0, 0, 2'b00, 0);
        add(0, 0, 9'h020, 0, 0, 2'b00, 0);
        add(1, 0, 9'h040, 0, 0, 2'b00, 0);
        add(0, 0, 9'h040, 0, 0, 2'b00, 0);
        add(1, 0, 9'h080, 0, 0, 2'b00, 0);
        add(0, 0, 9'h080, 0, 0, 2'b00, 0);
        add(1, 0, 9'h100, 0, 0, 2'b00, 0);
        add(0, 0, 9'h100, 0, 0, 2'b00, 0);
        add(1, 0, 9'h000, 1, 0, 2'b01, 0);
        add(0, 1, 9'h000, 1, 0, 2'b01, 0);
        add(0, 0, 9'h000, 1, 0, 2'b01, 0);
        add(0, 1, 9'h000, 1, 0, 2'b01, 0);
        add(0, 0, 9'h010, 1, 0, 2'b00, 0);
        // Three right round wins end the match.
        for (int k = 1; k <= 3; k++) begin
            for (int p = 0; p < 4; p++) begin
                add(0, 1, 9'h010 >> (p + 1), 1, 3'(k - 1), 2'b00, 0);
                add(0, 0, 9'h010 >> (p + 1), 1, 3'(k - 1), 2'b00, 0);
            end
            add(0, 1, 9'h000, 1, 3'(k), 2'b10, 0);
            for (int h = 0; h < 3; h++) add(0, 0, 9'h000, 1, 3'(k), 2'b10, 0);
            if (k < 3) add(0, 0, 9'h010, 1, 3'(k), 2'b00, 0);
            else       add(0, 0, 9'h000, 1, 3'(k), 2'b10, 1);
        end
        add(1, 0, 9'h000, 1, 3, 2'b10, 1);
        add(0, 0, 9'h000, 1, 3, 2'b10, 1);
        add(0, 1, 9'h000, 1, 3, 2'b10, 1);
        add(1, 1, 9'h000, 1, 3, 2'b10, 1);
        add(0, 0, 9'h000, 1, 3, 2'b10, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].l, vq[i].r);
            check($sformatf("vec%0d", i), vq[i].leds, vq[i].ls,
                  vq[i].rs, vq[i].win, vq[i].mo);
        end

        // Asynchronous reset in the middle of a left-win hold.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            step(0, 0);
        end
        step(1, 0);
        step(0, 0);
        step(0, 0);
        check("hold2", 9'h000, 3'd1, 3'd0, 2'b01, 1'b0);
        #2 reset = 1'b0;
        #1 check("async_rst", 9'h010, 3'd0, 3'd0, 2'b00, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(0, 0);
        check("post_rst", 9'h010, 3'd0, 3'd0, 2'b00, 1'b0);
`else
        // CPU always presses: right win within five cycles.
        cpu_thresh = 10'h3FF;
        do_reset();
        begin
            int n;
            n = 0;
            while (winner !== 2'b10 && n < 5) begin
                step(0, 0);
                n++;
            end
            check("cpu_win", 9'h000, 3'd0, 3'd1, 2'b10, 1'b0);
        end
        // CPU never presses: ball stays centred.
        cpu_thresh = 10'h000;
        do_reset();
        repeat (10) step(0, 1);
        check("cpu_idle", 9'h010, 3'd0, 3'd0, 2'b00, 1'b0);
        step(1, 0);
        check("cpu_l", 9'h020, 3'd0, 3'd0, 2'b00, 1'b0);
        #2 reset = 1'b0;
        #1 check("async_rst", 9'h010, 3'd0, 3'd0, 2'b00, 1'b0);
        #1 reset = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_of_war_field.md
Name: tug_of_war_field

Overview:
- Parametrised successor of the single-light tug-of-war cell. One block owns the whole playfield: a position register drives a one-hot LED bar of NUM_LIGHTS lights.
- Adds internal press edge-detection, round-win detection, per-player score counters, a post-win hold interval and a match-over state.
- Sits between the synchronised key inputs and the LEDR/HEX display drivers.

Parameters:
- NUM_LIGHTS, 9, LED bar length; odd, >= 3; centre index = NUM_LIGHTS/2
- SCORE_W, 3, width of each score counter
- MAX_SCORE, 3, round wins that end the match; 1 .. 2^SCORE_W-1
- HOLD_CYCLES, 4, cycles spent in a win state before the next round; >= 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- L  in  1  left-player key, level, already synchronised
- R  in  1  right-player key, level, already synchronised
- leds  out  NUM_LIGHTS  one-hot light bar; index NUM_LIGHTS-1 is leftmost
- l_score  out  SCORE_W  left rounds won
- r_score  out  SCORE_W  right rounds won
- winner  out  2  00 none, 01 left, 10 right
- match_over  out  1  high once a player reaches MAX_SCORE

Behaviour:
- Interface fact: one clock; reset is asynchronous and active-low.
- Reset state (reset=0, any time, including mid-round or mid-hold):
  - state=PLAY, pos=centre, leds=one-hot(centre)
  - scores=0, winner=00, match_over=0, hold counter=0, edge registers=0
- Edge detect: registered copies L_q/R_q. lp = L & ~L_q; rp = R & ~R_q.
  - A held key yields exactly one pulse.
  - Edge registers update in every state.
- Latency: pos/leds change at the first posedge where the new level is sampled (1 cycle).
- States PLAY, L_WIN, R_WIN, OVER:
  - PLAY, lp & ~rp:
    - pos < NUM_LIGHTS-1: pos+1.
    - pos == NUM_LIGHTS-1: -> L_WIN, l_score+1, winner=01, leds=0, hold=0.
  - PLAY, rp & ~lp:
    - pos > 0: pos-1.
    - pos == 0: -> R_WIN, r_score+1, winner=10, leds=0, hold=0.
  - PLAY, lp & rp, or no pulse: no change.
  - L_WIN/R_WIN:
    - Presses ignored; leds=0; hold increments each cycle.
    - At hold == HOLD_CYCLES-1:
      - winning score == MAX_SCORE: -> OVER.
      - otherwise: -> PLAY with pos=centre and winner=00.
  - OVER:
    - match_over=1, leds=0, winner and scores frozen, presses ignored.
    - Leaves only via reset.
- Scores never exceed MAX_SCORE, so there is no wrap.
- leds is a function of state and pos only; it never has more than one bit set.

Optional Feature:
- Macro TOW_CPU_PLAYER_EN.
- Defined:
  - Adds input cpu_thresh [9:0].
  - R is ignored; the right pulse comes from an internal 10-bit Fibonacci LFSR (taps 10,7; seed 10'h001 on reset).
  - rp = (lfsr < cpu_thresh), evaluated every cycle, with no edge detection.
- Undefined: port absent; R is used as specified above.

Decomposition:
- Package tow_pkg:
  - state enum {PLAY, L_WIN, R_WIN, OVER}
  - winner localparams WIN_NONE=2'b00, WIN_L=2'b01, WIN_R=2'b10
- Sub-module tow_edge_detect:
  - Async active-low reset, 1-bit level in, 1-cycle pulse out.
  - Instantiated twice, for L and R.
- Parametrised LFSR stays inline under the macro.

Test Plan:
All scenarios use defaults (NUM_LIGHTS=9, HOLD_CYCLES=4, MAX_SCORE=3).
1. Reset low 2 cycles then high -> leds=9'b000010000, scores 0, winner 00, match_over 0.
2. Hold L high 5 cycles -> leds=9'b000100000 after the first edge and unchanged thereafter (single move). Pulse L and R high in the same cycle -> leds unchanged.
3. Five separate L pulses from centre:
   - 5th pulse -> state L_WIN, leds=0, l_score=1, winner=01.
   - 4 cycles later -> leds=9'b000010000, winner=00.
   - R pulses during the hold are ignored.
4. Three right-player round wins (5 R pulses each) -> after the final hold: match_over=1, r_score=3, winner=10, leds=0. Further L/R pulses -> no change.
5. Assert reset mid-hold (L_WIN, hold=2) asynchronously between clock edges -> outputs return immediately to the reset values of scenario 1.
6. With TOW_CPU_PLAYER_EN and cpu_thresh=10'h3FF, no L input -> a right win within 5 cycles of reset release. With cpu_thresh=0 -> pos stays at centre.
